serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing A − B LSB-first, one bit per clock.
- Each step applies the half-subtractor difference/borrow equations, extended with a registered borrow-in.
- Sits downstream of operand registers and upstream of result consumers.
- Uses a start/done handshake. Trades latency (WIDTH cycles) for a single 1-bit subtract cell.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, one bit per clock.
// A single 1-bit subtract cell with a registered borrow walks WIDTH bits
// through shift registers; a start/done handshake frames each operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter only needs to reach WIDTH-1; the FSM leaves SHIFT before it wraps.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_last;

  // Full-subtract cell: returns {borrow_next, difference} for x - y - bin.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
    logic d;
    logic bo;
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {bo, d};
  endfunction

  // Datapath combinational terms for the current shift step.
  always_comb begin
    w_d       = 1'b0;
    w_br_next = 1'b0;
    {w_br_next, w_d} = sub_cell(r_sa[0], r_sb[0], r_br);
    w_sr_next = {w_d, r_sr[WIDTH-1:1]};
    w_last    = (r_cnt == CNT_LAST);
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand/result shifting, borrow flop, counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= W_ZERO;
      r_sb     <= W_ZERO;
      r_sr     <= W_ZERO;
      r_br     <= 1'b0;
      r_cnt    <= CNT_ZERO;
      r_diff   <= W_ZERO;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= W_ZERO;
            r_br  <= 1'b0;
            r_cnt <= CNT_ZERO;
          end
        end
        S_SHIFT: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sr  <= w_sr_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_diff   <= w_sr_next;
            r_borrow <= w_br_next;
          end
        end
        S_DONE: begin
          r_cnt <= CNT_ZERO;
        end
        default: begin
          r_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so they are glitch-free.
  assign busy       = (r_state == S_SHIFT);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  int n_cmp;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller must be at a negedge with the DUT idle. Returns at the idle negedge after done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ed, input logic eb, input string nm);
    int n;
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d exp 8", nm, n);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %b exp 1", nm, done);
    end
    n_cmp++;
    if (diff !== ed) begin
      n_fail++;
      $display("FAIL %s diff: a=%h b=%h got %h exp %h", nm, ia, ib, diff, ed);
    end
    n_cmp++;
    if (borrow_out !== eb) begin
      n_fail++;
      $display("FAIL %s borrow: a=%h b=%h got %b exp %b", nm, ia, ib, borrow_out, eb);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== ed) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b busy=%b diff=%h exp 0 0 %h", nm, done, busy, diff, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h bo=%b exp 0 0 00 0", busy, done, diff, borrow_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(8'h09, 8'h05, 8'h04, 1'b0, "9-5");
    do_op(8'h05, 8'h09, 8'hFC, 1'b1, "5-9");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, "0-1");
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, "FF-FF");
    do_op(8'h00, 8'h00, 8'h00, 1'b0, "0-0");
    do_op(8'hA5, 8'h5A, 8'h4B, 1'b0, "A5-5A");
    // Holds result across an idle gap.
    repeat (5) @(negedge clk);
    n_cmp++;
    if (diff !== 8'h4B || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: diff=%h bo=%b exp 4b 0", diff, borrow_out);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int pulses;
    start = 1'b1; a = 8'h03; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    n = 1;
    // Re-pulse start mid-SHIFT.
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || diff !== 8'h02 || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: done=%b diff=%h bo=%b exp 1 02 0", done, diff, borrow_out);
    end
    // Re-pulse start during DONE.
    pulses = 1;
    start = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_in_done: busy=%b done=%b exp 0 0", busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 1 || diff !== 8'h02) begin
      n_fail++;
      $display("FAIL ignore_pulses: pulses=%0d diff=%h exp 1 02", pulses, diff);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b exp 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: busy=%b done=%b diff=%h bo=%b exp 0 0 00 0", busy, done, diff, borrow_out);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: active_cycles=%0d exp 0", pulses);
    end
    do_op(8'h10, 8'h20, 8'hF0, 1'b1, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ed;
    do_op(8'h30, 8'h10, 8'h20, 1'b0, "b2b_1");
    do_op(8'h01, 8'h02, 8'hFF, 1'b1, "b2b_2");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ed = ra - rb;
      do_op(ra, rb, ed, (ra < rb), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
